counter_scheduler: RTL
======================

Name: counter_scheduler

Overview:
- Bank of NUM_REQ wrap-around counters that share one increment/wrap datapath.
- Serves the game-side event counters: mine/flag tallies, timer seconds, cursor steps.
- Each requester raises a level `req`. The block detects the rising edge, queues one pending service per channel, and grants one channel per clock in round-robin order.
- The granted channel's counter advances modulo its configured max. Per-channel wrap and drop pulses are reported to the draw logic.

Parameters:
- NUM_REQ, 4, number of requester channels (2..8).
- DATA_SIZE, 5, width of each counter and of each max value.

Ports:
- clk  in  1  system clock; all logic is synchronous to its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-channel count request (level); a rising edge requests one increment.
- clr  in  NUM_REQ  per-channel synchronous clear of counter and pending bit.
- cfg_we  in  1  max-register write strobe.
- cfg_sel  in  $clog2(NUM_REQ)  channel selected for the max write.
- cfg_max  in  DATA_SIZE  new max value.
- ctr_out  out  NUM_REQ*DATA_SIZE  packed counter values; channel i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- wrap  out  NUM_REQ  one-cycle pulse when the channel's counter wraps to 0.
- drop  out  NUM_REQ  one-cycle pulse when a request edge was lost.
- busy  out  1  high while any pending bit is set.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ctr, pend, req_q, wrap, drop cleared to 0.
  - rr_ptr = 0.
  - Every max register = all ones.
- Edge detect:
  - req_q <= req every cycle.
  - edge = req & ~req_q.
  - edge on channel i sets pend[i] at that clock edge.
- Arbitration:
  - Eligible set = pend & ~clr.
  - Grant the first eligible channel at or after rr_ptr, searching upward modulo NUM_REQ.
  - At most one grant per cycle.
  - On a grant: rr_ptr <= grant+1 (mod NUM_REQ) and pend[grant] cleared.
  - No eligible channel: rr_ptr holds.
- Service (DATA_SIZE-bit arithmetic):
  - ctr[g] <= (ctr[g] < max[g]-1) ? ctr[g]+1 : 0.
  - wrap[g] pulses in the same cycle ctr[g] loads 0.
- Latency:
  - req sampled high at edge k (req_q low): pend set at edge k; earliest ctr update at edge k+1.
  - Worst case with all channels pending: NUM_REQ cycles.
- max boundary cases:
  - max=0: max-1 = all ones, so the counter runs the full 0..2^DATA_SIZE-1 range.
  - max=1: counter stays 0 and wrap pulses on every service.
- Reconfiguration:
  - cfg_we writes max[cfg_sel] at the clock edge.
  - A service in the same cycle uses the old max.
  - If ctr >= new max-1, the next service wraps to 0.
- clr[i]:
  - ctr[i] <= 0 and pend[i] <= 0.
  - Channel i is not granted that cycle; the round-robin pointer skips it.
  - If edge[i] occurs in the same cycle, clr wins and no pend is set.
- Simultaneous edge and pending:
  - Channel granted this cycle plus a new edge: pend stays set (set wins over grant-clear).
  - pend already set, not granted, and a new edge: drop[i] pulses; pend stays 1 (no double count).
- busy = |pend (registered state, no combinational path from req).
- Reset asserted mid-service: the in-flight increment is discarded and all state returns to reset values.

Decomposition:
- Package `counter_pkg`:
  - localparam CTR_W default.
  - Function `ctr_next(ctr, max)` returning {wrap, next}, shared with the single-counter block.
- Sub-module `rr_arbiter` (parameter N):
  - Inputs: clk, rst_n, eligible[N].
  - Outputs: gnt_valid, gnt_idx; rotating pointer held inside.
- Top holds: req_q, pend, ctr array, max array, pulse outputs.

Test Plan:
- Single request: after reset, pulse req[0] for 3 clocks -> ctr0 = 1 two clocks after the rise; wrap = 0; busy high 1 cycle.
- Wrap at max:
  - cfg_max = 3 on ch1, then 3 req edges -> ctr1 sequence 1, 2, 0.
  - wrap[1] pulses on the third service.
  - cfg_max = 1 -> ctr1 stays 0 and wrap pulses every service.
- Round-robin fairness: edges on ch0..3 in the same cycle -> grants in order 0, 1, 2, 3 on consecutive cycles; busy is 4 cycles wide; every counter = 1.
- Drop and re-arm:
  - ch2 loses arbitration while a second edge arrives -> drop[2] pulses once and ctr2 advances by 1.
  - Edge arriving in ch2's grant cycle -> pend stays set and ctr2 advances by 2 in total.
- Clear collision:
  - clr[0] in the same cycle as edge[0], with ctr0 = 5 -> ctr0 = 0, no increment, rr_ptr skips ch0.
  - cfg write landing on a grant cycle -> the grant uses the old max.
- Async reset: rst_n low for a partial cycle while 3 channels are pending -> ctr_out = 0, wrap/drop/busy = 0, and all max registers read back all ones (max 31 with the default DATA_SIZE = 5).

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared definitions for the wrap-around counter bank: default
//                counter width and the common increment/wrap helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Default counter / max-register width.
    localparam int CTR_W     = 5;
    // Internal width of the shared datapath; counters up to CTR_MAX_W-1 bits.
    localparam int CTR_MAX_W = 32;

    // Result of one service step: wrap flag plus next counter value.
    typedef struct packed {
        logic                 wrap;
        logic [CTR_MAX_W-1:0] next;
    } ctr_res_t;

    // Advance a counter modulo its max. All compare arithmetic is done in
    // 'width' bits, so max = 0 yields max-1 = all ones (full range) and
    // max = 1 pins the counter at 0 with a wrap on every service.
    function automatic ctr_res_t ctr_next(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic [CTR_MAX_W-1:0] max,
        input int unsigned          width
    );
        logic [CTR_MAX_W-1:0] mask;
        logic [CTR_MAX_W-1:0] lim;
        ctr_res_t             res;
        mask = (CTR_MAX_W'(1) << width) - CTR_MAX_W'(1);
        lim  = (max - CTR_MAX_W'(1)) & mask;
        if (ctr < lim) begin
            res.wrap = 1'b0;
            res.next = ctr + CTR_MAX_W'(1);
        end else begin
            res.wrap = 1'b1;
            res.next = '0;
        end
        return res;
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Grants the first eligible channel at or
//                after the rotating pointer; pointer moves past each grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         eligible,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] r_ptr;

    // Search upward from the pointer, wrapping modulo N; first hit wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(r_ptr) + k) % N;
            if (!gnt_valid && eligible[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

    // Pointer advances to the slot after the winner; holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (gnt_valid) begin
            r_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/counter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : counter_scheduler
//  Description : Bank of NUM_REQ wrap-around counters sharing one increment
//                datapath. Request rising edges queue one pending service per
//                channel; one channel is serviced per clock in round-robin
//                order. Wrap and drop pulses are reported per channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_scheduler
    import counter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = CTR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             clr,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_REQ)-1:0]     cfg_sel,
    input  logic [DATA_SIZE-1:0]           cfg_max,
    output logic [NUM_REQ*DATA_SIZE-1:0]   ctr_out,
    output logic [NUM_REQ-1:0]             wrap,
    output logic [NUM_REQ-1:0]             drop,
    output logic                           busy
);

    localparam int SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   r_req_q;
    logic [NUM_REQ-1:0]   r_pend;
    logic [NUM_REQ-1:0]   r_wrap;
    logic [NUM_REQ-1:0]   r_drop;
    logic [DATA_SIZE-1:0] r_ctr [NUM_REQ];
    logic [DATA_SIZE-1:0] r_max [NUM_REQ];

    logic [NUM_REQ-1:0]   w_edge;
    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_gnt_valid;
    logic [SEL_W-1:0]     w_gnt_idx;
    logic [NUM_REQ-1:0]   w_gnt_onehot;
    ctr_res_t             w_svc;
    logic [DATA_SIZE-1:0] w_svc_next;
    logic                 w_unused_hi;

    // A cleared channel is never eligible, so clear always beats service.
    assign w_edge = req & ~r_req_q;
    assign w_elig = r_pend & ~clr;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .eligible  (w_elig),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Decode the winning index into a per-channel grant strobe.
    always_comb begin
        w_gnt_onehot = '0;
        if (w_gnt_valid) begin
            w_gnt_onehot[w_gnt_idx] = 1'b1;
        end
    end

    // Single shared increment/wrap datapath, fed from the granted channel.
    assign w_svc       = ctr_next(CTR_MAX_W'(r_ctr[w_gnt_idx]),
                                  CTR_MAX_W'(r_max[w_gnt_idx]),
                                  DATA_SIZE);
    assign w_svc_next  = w_svc.next[DATA_SIZE-1:0];
    assign w_unused_hi = |w_svc.next[CTR_MAX_W-1:DATA_SIZE];

    // Edge history, pending flags and the wrap/drop pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q <= '0;
            r_pend  <= '0;
            r_wrap  <= '0;
            r_drop  <= '0;
        end else begin
            r_req_q <= req;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wrap[i] <= w_gnt_onehot[i] & w_svc.wrap;
                // A new edge on an already-pending, unserved channel is lost.
                r_drop[i] <= w_edge[i] & r_pend[i] & ~w_gnt_onehot[i] & ~clr[i];
                if (clr[i]) begin
                    r_pend[i] <= 1'b0;
                end else if (w_edge[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (w_gnt_onehot[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Counter and max-register bank; service reads the pre-write max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_ctr[i] <= '0;
                r_max[i] <= '1;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (clr[i]) begin
                    r_ctr[i] <= '0;
                end else if (w_gnt_onehot[i]) begin
                    r_ctr[i] <= w_svc_next;
                end
                if (cfg_we && (cfg_sel == SEL_W'(i))) begin
                    r_max[i] <= cfg_max;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
            assign ctr_out[g*DATA_SIZE +: DATA_SIZE] = r_ctr[g];
        end
    endgenerate

    assign wrap = r_wrap;
    assign drop = r_drop;
    assign busy = |r_pend;

endmodule : counter_scheduler
`default_nettype wire
